// File: rtl/pacman_pkg.sv
// Shared encodings and maze/display geometry for the sprite motion engine.
package pacman_pkg;

    localparam int TILE_LOG2       = 4;
    localparam int MOVE_TO_CENTER  = 7;
    localparam int H_VISIBLE_START = 336;
    localparam int V_VISIBLE_START = 27;

    localparam logic [3:0] DIR_R = 4'b0001;
    localparam logic [3:0] DIR_L = 4'b0010;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_D = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QREQ,
        ST_QCUR,
        ST_MOVE
    } mc_state_e;

    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        case (d)
            DIR_R:   return DIR_L;
            DIR_L:   return DIR_R;
            DIR_U:   return DIR_D;
            DIR_D:   return DIR_U;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/pacman_motion_ctrl_move_tick_gen.sv
// Free-running divider: one-cycle tick every STEP_DIV clocks (on count STEP_DIV-1).
module move_tick_gen #(
    parameter int STEP_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(STEP_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Maze sprite mover: buffered turn request, wall-query handshake, tunnel wrap,
// paced by move_tick_gen and holdable by freeze.
module pacman_motion_ctrl #(
    parameter int STEP_DIV        = 1_000_000,
    parameter int TILE_LOG2       = pacman_pkg::TILE_LOG2,
    parameter int MOVE_TO_CENTER  = pacman_pkg::MOVE_TO_CENTER,
    parameter int H_VISIBLE_START = pacman_pkg::H_VISIBLE_START,
    parameter int V_VISIBLE_START = pacman_pkg::V_VISIBLE_START,
    parameter int MAP_COLS        = 28,
    parameter int MAP_ROWS        = 31,
    parameter int START_COL       = 14,
    parameter int START_ROW       = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rbtn,
    input  logic        lbtn,
    input  logic        ubtn,
    input  logic        dbtn,
    input  logic        freeze,
    output logic        wq_valid,
    input  logic        wq_ready,
    output logic [6:0]  wq_idx_x,
    output logic [5:0]  wq_idx_y,
    input  logic        wq_wall,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y,
    output logic [6:0]  mat_idx_x,
    output logic [5:0]  mat_idx_y,
    output logic [3:0]  dir_out,
    output logic        at_center
);
    import pacman_pkg::*;

    localparam int TILE = 1 << TILE_LOG2;
    localparam logic [10:0] X_MIN = 11'(H_VISIBLE_START);
    localparam logic [10:0] X_MAX = 11'(H_VISIBLE_START + MAP_COLS * TILE - 1);
    localparam logic [9:0]  Y_MIN = 10'(V_VISIBLE_START);
    localparam logic [10:0] X_RST = 11'(H_VISIBLE_START + START_COL * TILE + MOVE_TO_CENTER);
    localparam logic [9:0]  Y_RST = 10'(V_VISIBLE_START + START_ROW * TILE + MOVE_TO_CENTER);
    localparam logic [TILE_LOG2-1:0] CTR = TILE_LOG2'(MOVE_TO_CENTER);

    mc_state_e   state_q, state_d;
    logic [10:0] pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic [3:0]  dir_q, dir_d;
    logic [3:0]  req_dir_q, req_dir_d;
    logic [3:0]  qdir_q, qdir_d;
    logic        pend_q, pend_d;
    logic        tick, consume;

    logic [10:0] off_x;
    logic [9:0]  off_y;
    logic [3:0]  q_dir;
    logic [6:0]  nb_x;
    logic [5:0]  nb_y;

    move_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign off_x     = pos_x_q - X_MIN;
    assign off_y     = pos_y_q - Y_MIN;
    assign mat_idx_x = 7'(off_x >> TILE_LOG2);
    assign mat_idx_y = 6'(off_y >> TILE_LOG2);
    assign at_center = (off_x[TILE_LOG2-1:0] == CTR) && (off_y[TILE_LOG2-1:0] == CTR);
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign dir_out   = dir_q;

    // The turn query uses the direction latched on entry so the index stays put while waiting.
    always_comb begin
        q_dir = (state_q == ST_QREQ) ? qdir_q : dir_q;
        nb_x  = mat_idx_x;
        nb_y  = mat_idx_y;
        case (q_dir)
            DIR_R:   nb_x = (mat_idx_x == 7'(MAP_COLS - 1)) ? 7'd0 : mat_idx_x + 7'd1;
            DIR_L:   nb_x = (mat_idx_x == 7'd0) ? 7'(MAP_COLS - 1) : mat_idx_x - 7'd1;
            DIR_U:   nb_y = (mat_idx_y == 6'd0) ? 6'd0 : mat_idx_y - 6'd1;
            DIR_D:   nb_y = (mat_idx_y == 6'(MAP_ROWS - 1)) ? mat_idx_y : mat_idx_y + 6'd1;
            default: ;
        endcase
        wq_idx_x = nb_x;
        wq_idx_y = nb_y;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_d    = dir_q;
        qdir_d   = qdir_q;
        consume  = 1'b0;
        wq_valid = 1'b0;

        if      (rbtn) req_dir_d = DIR_R;
        else if (lbtn) req_dir_d = DIR_L;
        else if (ubtn) req_dir_d = DIR_U;
        else if (dbtn) req_dir_d = DIR_D;
        else           req_dir_d = req_dir_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_q && !freeze) begin
                    consume = 1'b1;
                    if (req_dir_q == dir_opposite(dir_q)) begin
                        dir_d   = req_dir_q;
                        state_d = ST_MOVE;
                    end else if (!at_center) begin
                        state_d = ST_MOVE;
                    end else if (req_dir_q != dir_q) begin
                        qdir_d  = req_dir_q;
                        state_d = ST_QREQ;
                    end else begin
                        state_d = ST_QCUR;
                    end
                end
            end
            ST_QREQ: begin
                wq_valid = 1'b1;
                if (wq_ready) begin
                    if (!wq_wall) dir_d = qdir_q;
                    state_d = ST_QCUR;
                end
            end
            ST_QCUR: begin
                wq_valid = 1'b1;
                if (wq_ready) state_d = wq_wall ? ST_IDLE : ST_MOVE;
            end
            ST_MOVE: begin
                // A freeze arriving after the query completed parks the move until release.
                if (!freeze) begin
                    state_d = ST_IDLE;
                    case (dir_q)
                        DIR_R:   pos_x_d = (pos_x_q == X_MAX) ? X_MIN : pos_x_q + 11'd1;
                        DIR_L:   pos_x_d = (pos_x_q == X_MIN) ? X_MAX : pos_x_q - 11'd1;
                        DIR_U:   pos_y_d = pos_y_q - 10'd1;
                        DIR_D:   pos_y_d = pos_y_q + 10'd1;
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d = (pend_q && !consume) || tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pos_x_q   <= X_RST;
            pos_y_q   <= Y_RST;
            dir_q     <= DIR_R;
            req_dir_q <= DIR_R;
            qdir_q    <= DIR_R;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            req_dir_q <= req_dir_d;
            qdir_q    <= qdir_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Directed bench for pacman_motion_ctrl with STEP_DIV=4 and a one-wall map model.
module tb_pacman_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rbtn, lbtn, ubtn, dbtn, freeze;
    logic        wq_valid, wq_ready, wq_wall;
    logic [6:0]  wq_idx_x;
    logic [5:0]  wq_idx_y;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic [6:0]  mat_idx_x;
    logic [5:0]  mat_idx_y;
    logic [3:0]  dir_out;
    logic        at_center;

    logic        wall_en;
    logic [6:0]  wall_x;
    logic [5:0]  wall_y;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    logic [6:0] last_qx;
    logic [5:0] last_qy;

    always #5 clk = ~clk;

    assign wq_wall = wall_en && (wq_idx_x == wall_x) && (wq_idx_y == wall_y);

    pacman_motion_ctrl #(.STEP_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rbtn      (rbtn),
        .lbtn      (lbtn),
        .ubtn      (ubtn),
        .dbtn      (dbtn),
        .freeze    (freeze),
        .wq_valid  (wq_valid),
        .wq_ready  (wq_ready),
        .wq_idx_x  (wq_idx_x),
        .wq_idx_y  (wq_idx_y),
        .wq_wall   (wq_wall),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .mat_idx_x (mat_idx_x),
        .mat_idx_y (mat_idx_y),
        .dir_out   (dir_out),
        .at_center (at_center)
    );

    always @(posedge clk) begin
        if (wq_valid && wq_ready) begin
            hs_cnt  <= hs_cnt + 1;
            last_qx <= wq_idx_x;
            last_qy <= wq_idx_y;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rbtn = 1'b0; lbtn = 1'b0; ubtn = 1'b0; dbtn = 1'b0;
        freeze = 1'b0; wq_ready = 1'b1;
        wall_en = 1'b0; wall_x = '0; wall_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_x(input logic [10:0] target, input int budget, output int cycles);
        cycles = 0;
        while (pos_x !== target && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_y(input logic [9:0] target, input int budget);
        int c = 0;
        while (pos_y !== target && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int cyc;
        int hs0;
        int bad;
        logic [6:0] hold_x;
        logic [5:0] hold_y;

        // 1: reset state
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        check("rst_pos_x", 32'(pos_x), 567);
        check("rst_pos_y", 32'(pos_y), 402);
        check("rst_idx_x", 32'(mat_idx_x), 14);
        check("rst_idx_y", 32'(mat_idx_y), 23);
        check("rst_dir", 32'(dir_out), 1);
        check("rst_center", 32'(at_center), 1);
        check("rst_wq_valid", 32'(wq_valid), 0);

        // 2: open map, rbtn held, one pixel per tick
        do_reset();
        rbtn = 1'b1;
        wait_x(11'd583, 100, cyc);
        check("t2_pos_x", 32'(pos_x), 583);
        check("t2_idx_x", 32'(mat_idx_x), 15);
        check("t2_center", 32'(at_center), 1);
        check("t2_rate", 32'(cyc >= 60 && cyc <= 72), 1);

        // 3: wall right of start, blocked, one query per tick
        do_reset();
        wall_en = 1'b1; wall_x = 7'd15; wall_y = 6'd23;
        rbtn = 1'b1;
        hs0 = hs_cnt;
        repeat (40) @(negedge clk);
        check("t3_pos_x", 32'(pos_x), 567);
        check("t3_qcount", 32'((hs_cnt - hs0) >= 9 && (hs_cnt - hs0) <= 10), 1);
        check("t3_qidx_x", 32'(last_qx), 15);
        check("t3_qidx_y", 32'(last_qy), 23);

        // 4: buffered up-turn taken at next centre
        do_reset();
        rbtn = 1'b1;
        wait_x(11'd570, 40, cyc);
        check("t4_at570", 32'(pos_x), 570);
        rbtn = 1'b0; ubtn = 1'b1;
        @(negedge clk);
        ubtn = 1'b0;
        wait_x(11'd583, 80, cyc);
        check("t4_pos_x", 32'(pos_x), 583);
        check("t4_dir_before", 32'(dir_out), 1);
        wait_y(10'd401, 20);
        check("t4_pos_y", 32'(pos_y), 401);
        check("t4_dir_after", 32'(dir_out), 4);
        check("t4_pos_x_hold", 32'(pos_x), 583);

        // 5: reversal off-centre without a query
        do_reset();
        rbtn = 1'b1;
        wait_x(11'd570, 40, cyc);
        rbtn = 1'b0; lbtn = 1'b1;
        hs0 = hs_cnt;
        @(negedge clk);
        lbtn = 1'b0;
        wait_x(11'd569, 20, cyc);
        check("t5_pos_x", 32'(pos_x), 569);
        check("t5_dir", 32'(dir_out), 2);
        check("t5_no_query", 32'(hs_cnt - hs0), 0);

        // 6: keep going left into the tunnel
        wait_x(11'd336, 1100, cyc);
        check("t6_at336", 32'(pos_x), 336);
        wait_x(11'd783, 10, cyc);
        check("t6_wrap_x", 32'(pos_x), 783);
        check("t6_wrap_idx", 32'(mat_idx_x), 27);
        check("t6_center", 32'(at_center), 0);

        // 7: freeze with a stalled query, then async reset mid-query
        do_reset();
        wq_ready = 1'b0;
        cyc = 0;
        while (!wq_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t7_valid_up", 32'(wq_valid), 1);
        hold_x = wq_idx_x; hold_y = wq_idx_y;
        freeze = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!wq_valid || wq_idx_x !== hold_x || wq_idx_y !== hold_y) bad++;
        end
        check("t7_query_held", 32'(bad), 0);
        check("t7_qidx_x", 32'(hold_x), 15);
        check("t7_pos_x", 32'(pos_x), 567);
        #2;
        rst = 1'b0;
        #1;
        check("t7_async_drop", 32'(wq_valid), 0);

        // 8: button priority L over U gives a reversal
        do_reset();
        lbtn = 1'b1; ubtn = 1'b1;
        @(negedge clk);
        lbtn = 1'b0; ubtn = 1'b0;
        wait_x(11'd566, 20, cyc);
        check("t8_pos_x", 32'(pos_x), 566);
        check("t8_dir", 32'(dir_out), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
